// File: rtl/pe_array_pkg.sv
// Shared constants and types for the PE array command sequencer.
// Command codes, shift targets, FSM states and op selectors.
package pe_array_pkg;

  localparam logic [2:0] CMD_NOP   = 3'b000;
  localparam logic [2:0] CMD_MAC   = 3'b001;
  localparam logic [2:0] CMD_SHIFT = 3'b010;
  localparam logic [2:0] CMD_CLEAR = 3'b100;
  localparam logic [2:0] CMD_LOAD  = 3'b101;
  localparam logic [2:0] CMD_READ  = 3'b110;

  localparam logic IMG_A = 1'b0;
  localparam logic IMG_B = 1'b1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_BUSY,
    S_WAIT_DONE,
    S_NEXT,
    S_FINISH
  } seq_state_t;

  typedef enum logic [2:0] {
    OP_CLEAR,
    OP_LOAD,
    OP_MAC,
    OP_SHA,
    OP_SHB,
    OP_READ
  } op_t;

  function automatic logic [2:0] op_cmd(input op_t op);
    case (op)
      OP_CLEAR: return CMD_CLEAR;
      OP_LOAD:  return CMD_LOAD;
      OP_MAC:   return CMD_MAC;
      OP_SHA:   return CMD_SHIFT;
      OP_SHB:   return CMD_SHIFT;
      OP_READ:  return CMD_READ;
      default:  return CMD_NOP;
    endcase
  endfunction

  function automatic logic op_img(input op_t op);
    return (op == OP_SHB) ? IMG_B : IMG_A;
  endfunction

endpackage

// File: rtl/pe_cmd_handshake.sv
// Presents one command to the array and tracks ready.
// Strobes cmd_done / cmd_timeout back to the sequencer.
module pe_cmd_handshake
  import pe_array_pkg::*;
#(
  parameter int TIMEOUT  = 1024,
  parameter int TO_WIDTH = $clog2(TIMEOUT)
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       cmd_valid,
  input  logic [2:0] cmd_in,
  input  logic       img_in,
  input  logic       abort,
  input  logic       ready,
  output logic       cmd_done,
  output logic       cmd_timeout,
  output logic       array_ack,
  output logic [2:0] command_to_execute,
  output logic       image_to_shift
);

  seq_state_t          state;
  logic [TO_WIDTH-1:0] cnt;
  logic                expired;
  logic                waiting;

  assign expired = (cnt == TO_WIDTH'(TIMEOUT - 1));

  // Abort masks both completion and timeout strobes.
  always_comb begin
    waiting     = 1'b0;
    cmd_done    = 1'b0;
    cmd_timeout = 1'b0;
    if (state == S_WAIT_BUSY)
      waiting = ready;
    if (state == S_WAIT_DONE)
      waiting = !ready;
    if (!abort) begin
      cmd_done    = (state == S_WAIT_DONE) && ready;
      cmd_timeout = waiting && expired;
    end
  end

  // Handshake FSM with registered array-side outputs.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state              <= S_IDLE;
      cnt                <= '0;
      array_ack          <= 1'b1;
      command_to_execute <= CMD_NOP;
      image_to_shift     <= IMG_A;
    end else if (abort || cmd_done || cmd_timeout) begin
      state              <= S_IDLE;
      array_ack          <= 1'b1;
      command_to_execute <= CMD_NOP;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            command_to_execute <= cmd_in;
            image_to_shift     <= img_in;
            array_ack          <= 1'b0;
            cnt                <= '0;
            state              <= S_WAIT_BUSY;
          end
        end
        S_WAIT_BUSY: begin
          if (!ready) begin
            cnt   <= '0;
            state <= S_WAIT_DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_WAIT_DONE: cnt <= cnt + 1'b1;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/pe_array_sequencer.sv
// Runs a full matrix-multiply job as a fixed command series:
// CLEAR, LOAD, K MACs with A/B shifts between, then READ.
module pe_array_sequencer
  import pe_array_pkg::*;
#(
  parameter int K_WIDTH  = 8,
  parameter int TIMEOUT  = 1024,
  parameter int TO_WIDTH = $clog2(TIMEOUT)
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               start,
  input  logic [K_WIDTH-1:0] k_steps,
  input  logic               abort,
  output logic               busy,
  output logic               done,
  output logic               error,
  output logic [K_WIDTH-1:0] step_count,
  input  logic               ready,
  output logic               array_ack,
  output logic [2:0]         command_to_execute,
  output logic               image_to_shift
);

  seq_state_t         state;
  op_t                op;
  logic [K_WIDTH-1:0] k_lat;
  logic               cmd_valid;
  logic               cmd_done;
  logic               cmd_timeout;

  assign cmd_valid = (state == S_ISSUE);

  pe_cmd_handshake #(
    .TIMEOUT  (TIMEOUT),
    .TO_WIDTH (TO_WIDTH)
  ) u_hs (
    .CLK                (CLK),
    .RST                (RST),
    .cmd_valid          (cmd_valid),
    .cmd_in             (op_cmd(op)),
    .img_in             (op_img(op)),
    .abort              (abort),
    .ready              (ready),
    .cmd_done           (cmd_done),
    .cmd_timeout        (cmd_timeout),
    .array_ack          (array_ack),
    .command_to_execute (command_to_execute),
    .image_to_shift     (image_to_shift)
  );

  // Job sequencer; one wait state covers the whole handshake.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= S_IDLE;
      op         <= OP_CLEAR;
      k_lat      <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
      step_count <= '0;
    end else begin
      done <= 1'b0;
      if (abort && state != S_IDLE) begin
        state <= S_IDLE;
        busy  <= 1'b0;
      end else begin
        unique case (state)
          S_IDLE: begin
            if (start && k_steps != '0) begin
              k_lat      <= k_steps;
              error      <= 1'b0;
              step_count <= '0;
              op         <= OP_CLEAR;
              busy       <= 1'b1;
              state      <= S_ISSUE;
            end
          end
          S_ISSUE: state <= S_WAIT_BUSY;
          S_WAIT_BUSY: begin
            if (cmd_timeout) begin
              error <= 1'b1;
              busy  <= 1'b0;
              state <= S_IDLE;
            end else if (cmd_done) begin
              if (op == OP_MAC)
                step_count <= step_count + 1'b1;
              state <= S_NEXT;
            end
          end
          S_NEXT: begin
            state <= S_ISSUE;
            unique case (op)
              OP_CLEAR: op <= OP_LOAD;
              OP_LOAD:  op <= OP_MAC;
              OP_MAC: begin
                if (step_count == k_lat)
                  op <= OP_READ;
                else
                  op <= OP_SHA;
              end
              OP_SHA: op <= OP_SHB;
              OP_SHB: op <= OP_MAC;
              default: begin
                done  <= 1'b1;
                busy  <= 1'b0;
                state <= S_FINISH;
              end
            endcase
          end
          S_FINISH: state <= S_IDLE;
          default:  state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pe_array_sequencer.sv
// Directed + randomized bench for pe_array_sequencer.
// Reactive array model records every presented command.
module tb_pe_array_sequencer;

  localparam int KW  = 8;
  localparam int TMO = 16;

  localparam logic [2:0] C_MAC   = 3'b001;
  localparam logic [2:0] C_SHIFT = 3'b010;
  localparam logic [2:0] C_CLEAR = 3'b100;
  localparam logic [2:0] C_LOAD  = 3'b101;
  localparam logic [2:0] C_READ  = 3'b110;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          start = 1'b0;
  logic [KW-1:0] k_steps = '0;
  logic          abort = 1'b0;
  logic          ready = 1'b1;
  logic          busy, done, error;
  logic [KW-1:0] step_count;
  logic          array_ack, image_to_shift;
  logic [2:0]    command_to_execute;

  int checks = 0;
  int failures = 0;
  int done_cnt = 0;
  int arr_cnt = 0;
  bit stuck = 1'b0;
  bit abort_req = 1'b0;
  logic [3:0] cmd_q[$];
  logic [3:0] exp_q[$];

  always #5 CLK = ~CLK;

  pe_array_sequencer #(.K_WIDTH(KW), .TIMEOUT(TMO)) dut (
    .CLK                (CLK),
    .RST                (RST),
    .start              (start),
    .k_steps            (k_steps),
    .abort              (abort),
    .busy               (busy),
    .done               (done),
    .error              (error),
    .step_count         (step_count),
    .ready              (ready),
    .array_ack          (array_ack),
    .command_to_execute (command_to_execute),
    .image_to_shift     (image_to_shift)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  always @(negedge CLK)
    if (done === 1'b1) done_cnt++;

  // Array model: drops ready one cycle after a command appears,
  // raises it a random 2..4 cycles later; optional stuck/abort.
  initial begin
    logic [3:0] cur;
    int target;
    cur = '0;
    target = 3;
    forever begin
      @(negedge CLK);
      abort = 1'b0;
      if (array_ack !== 1'b0) begin
        arr_cnt = 0;
        ready = 1'b1;
      end else if (arr_cnt == 0) begin
        cur = {command_to_execute, image_to_shift};
        cmd_q.push_back(cur);
        arr_cnt = 1;
        target = $urandom_range(3, 5);
        if (!(stuck && command_to_execute == C_LOAD))
          ready = 1'b0;
      end else begin
        chk("hold_stable",
            32'({command_to_execute, image_to_shift}), 32'(cur));
        if (ready == 1'b0) begin
          arr_cnt++;
          if (arr_cnt == target) begin
            ready = 1'b1;
            if (abort_req && cmd_q.size() == 6) begin
              abort = 1'b1;
              abort_req = 1'b0;
            end
          end
        end
      end
    end
  end

  task automatic build_exp(input int k);
    exp_q.delete();
    exp_q.push_back({C_CLEAR, 1'b0});
    exp_q.push_back({C_LOAD, 1'b0});
    for (int i = 1; i <= k; i++) begin
      exp_q.push_back({C_MAC, 1'b0});
      if (i < k) begin
        exp_q.push_back({C_SHIFT, 1'b0});
        exp_q.push_back({C_SHIFT, 1'b1});
      end
    end
    exp_q.push_back({C_READ, 1'b0});
  endtask

  task automatic compare_list();
    logic [3:0] a, e;
    chk("cmd_count", cmd_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < cmd_q.size(); i++) begin
      a = cmd_q[i];
      e = exp_q[i];
      chk($sformatf("cmd_seq[%0d]", i), 32'(a[3:1]), 32'(e[3:1]));
      if (e[3:1] == C_SHIFT)
        chk($sformatf("shift_tgt[%0d]", i), 32'(a[0]), 32'(e[0]));
    end
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_error"}, 32'(error), 0);
    chk({tag, "_step"}, 32'(step_count), 0);
    chk({tag, "_ack"}, 32'(array_ack), 1);
    chk({tag, "_cmd"}, 32'(command_to_execute), 0);
    chk({tag, "_img"}, 32'(image_to_shift), 0);
  endtask

  task automatic run_job(input int k, input bit pulse);
    int base;
    bit seen;
    base = done_cnt;
    build_exp(k);
    @(negedge CLK);
    cmd_q.delete();
    start = 1'b1;
    k_steps = KW'(k);
    @(negedge CLK);
    start = 1'b0;
    k_steps = KW'($urandom);
    chk("busy_after_start", 32'(busy), 1);
    chk("error_cleared", 32'(error), 0);
    seen = 1'b0;
    for (int c = 0; c < 20000 && !seen; c++) begin
      if (done === 1'b1) begin
        seen = 1'b1;
        start = 1'b0;
        chk("busy_low_at_done", 32'(busy), 0);
        chk("step_count", 32'(step_count), 32'(k));
      end else begin
        if (pulse) begin
          start = (c % 7 == 3);
          k_steps = KW'($urandom);
        end
        @(negedge CLK);
      end
    end
    start = 1'b0;
    chk("done_seen", 32'(seen), 1);
    @(negedge CLK);
    chk("done_one_cycle", 32'(done), 0);
    repeat (3) @(negedge CLK);
    chk("done_pulses", done_cnt - base, 1);
    chk("error_end", 32'(error), 0);
    compare_list();
  endtask

  initial begin
    int n;
    int base;
    int sz;
    repeat (3) @(negedge CLK);
    check_reset_vals("reset");
    RST = 1'b0;

    // Basic jobs
    run_job(1, 1'b0);
    run_job(3, 1'b0);
    for (int r = 0; r < 4; r++)
      run_job($urandom_range(1, 6), 1'b0);

    // Timeout on LOAD, then recovery
    stuck = 1'b1;
    base = done_cnt;
    @(negedge CLK);
    start = 1'b1;
    k_steps = KW'(1);
    @(negedge CLK);
    start = 1'b0;
    for (int c = 0; c < 100; c++) begin
      if (array_ack === 1'b0 && command_to_execute == C_LOAD) break;
      @(negedge CLK);
    end
    n = 0;
    while (array_ack === 1'b0 && n < 200) begin
      n++;
      @(negedge CLK);
    end
    chk("timeout_cycles", n, TMO);
    chk("timeout_error", 32'(error), 1);
    chk("timeout_ack", 32'(array_ack), 1);
    chk("timeout_cmd", 32'(command_to_execute), 0);
    chk("timeout_busy", 32'(busy), 0);
    repeat (3) @(negedge CLK);
    chk("timeout_no_done", done_cnt - base, 0);
    chk("error_sticky", 32'(error), 1);
    stuck = 1'b0;
    run_job(1, 1'b0);

    // Abort coincident with ready rising on second MAC
    base = done_cnt;
    abort_req = 1'b1;
    @(negedge CLK);
    cmd_q.delete();
    start = 1'b1;
    k_steps = KW'(3);
    @(negedge CLK);
    start = 1'b0;
    n = 0;
    while (abort_req && n < 500) begin
      n++;
      @(negedge CLK);
    end
    chk("abort_reached", 32'(abort_req), 0);
    @(negedge CLK);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_ack", 32'(array_ack), 1);
    chk("abort_cmd", 32'(command_to_execute), 0);
    chk("abort_step", 32'(step_count), 1);
    repeat (4) @(negedge CLK);
    chk("abort_no_done", done_cnt - base, 0);
    chk("abort_idle_ack", 32'(array_ack), 1);

    // Reset mid-SHIFT, then a zero-length start
    @(negedge CLK);
    cmd_q.delete();
    start = 1'b1;
    k_steps = KW'(2);
    @(negedge CLK);
    start = 1'b0;
    n = 0;
    while (cmd_q.size() < 4 && n < 500) begin
      n++;
      @(negedge CLK);
    end
    chk("reached_shift", 32'(cmd_q[cmd_q.size()-1][3:1]), 32'(C_SHIFT));
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    check_reset_vals("midrst");
    sz = cmd_q.size();
    start = 1'b1;
    k_steps = '0;
    @(negedge CLK);
    start = 1'b0;
    for (int c = 0; c < 5; c++) begin
      chk("k0_busy", 32'(busy), 0);
      @(negedge CLK);
    end
    chk("k0_no_cmd", cmd_q.size(), sz);

    // Start pulses while busy, then longest job
    run_job(3, 1'b1);
    run_job(255, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pe_array_sequencer.md
Name: pe_array_sequencer

Overview:
- Command sequencer for the PE array: runs one complete matrix-multiply job as a fixed series of array commands.
- For each command it drives `command_to_execute`, `image_to_shift` and `array_ack`, then tracks the array's `ready` handshake.
- Sits between the host control logic (start/done) and `pe_array`.
- Adds a watchdog timeout and an abort path.

Parameters:
- K_WIDTH, 8, width of `k_steps` and `step_count`.
- TIMEOUT, 1024, maximum cycles to wait in either handshake wait state before declaring an error.
- TO_WIDTH, $clog2(TIMEOUT), width of the timeout counter.

Ports:
- CLK  in  1  system clock.
- RST  in  1  reset; one clock, synchronous, active-high.
- start  in  1  job request, sampled only in IDLE.
- k_steps  in  K_WIDTH  number of MAC steps; latched on an accepted start.
- abort  in  1  cancel the current job.
- busy  out  1  high from the cycle after an accepted start until return to IDLE.
- done  out  1  one-cycle pulse on successful job completion.
- error  out  1  sticky handshake-timeout flag.
- step_count  out  K_WIDTH  number of MACs completed in the current job.
- ready  in  1  array status: 0 = executing a command, 1 = idle/complete.
- array_ack  out  1  0 = a command is presented, 1 = idle/hold.
- command_to_execute  out  3  array command.
- image_to_shift  out  1  shift target: 0 = A, 1 = B.

Behaviour:
- Command encoding:
  - 000 NOP
  - 001 MAC
  - 010 SHIFT (target selected by `image_to_shift`)
  - 100 CLEAR accumulators
  - 101 LOAD overwrite arrays
  - 110 READ
  - 011 and 111 reserved, never issued.
- Reset values: `array_ack`=1, `command_to_execute`=000, `image_to_shift`=0, `busy`=0, `done`=0, `error`=0, `step_count`=0, state=IDLE. All outputs are registered.
- Job sequence for K = `k_steps`:
  - CLEAR, then LOAD.
  - K MACs. Between consecutive MACs: SHIFT with `image_to_shift`=0, then SHIFT with `image_to_shift`=1.
  - READ.
  - Total commands = 3K+1.
- States: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, NEXT, FINISH.
- IDLE:
  - `start`=1 and `k_steps`≠0: latch K, clear `error` and `step_count`, next op = CLEAR, go to ISSUE.
  - `start` with `k_steps`=0 is ignored; `busy` stays 0.
- ISSUE: register the command and target, set `array_ack`=0, go to WAIT_BUSY next cycle.
- WAIT_BUSY: on `ready`=0 go to WAIT_DONE.
- WAIT_DONE:
  - On `ready`=1: set `array_ack`=1 and `command_to_execute`=NOP; if the op was MAC, increment `step_count`; go to NEXT.
  - `command_to_execute`/`image_to_shift` stay stable from ISSUE until this point.
- NEXT: select the next op per the sequence, then go to ISSUE. After READ, go to FINISH instead.
- FINISH: `done`=1 for exactly one cycle, then IDLE (`busy` drops in the same cycle as `done`).
- Minimum per-command overhead: 4 cycles, with `ready` responding in zero wait.
- Timeout:
  - The counter resets on entry to WAIT_BUSY and to WAIT_DONE.
  - If TIMEOUT cycles elapse without the awaited `ready` level: `error`=1 (sticky), `array_ack`=1, cmd=NOP, go to IDLE, no `done`.
- Abort:
  - In any non-IDLE state: next cycle `array_ack`=1, cmd=NOP, IDLE, `busy`=0, no `done`, `error` unchanged.
  - Abort in IDLE has no effect.
  - Abort takes priority over a simultaneous `ready` transition or a simultaneous timeout.
- Ignored inputs: `start` while busy is ignored. Changes to `k_steps` after acceptance are ignored.
- Reset mid-job returns all outputs to their reset values in the next cycle; the array is expected to drop its work on `array_ack`=1.
- `ready` already 0 when entering WAIT_BUSY: advance immediately.
- K = 2^K_WIDTH−1 must run fully. `step_count` never wraps within a job.

Decomposition:
- Package pe_array_pkg:
  - command localparams (CMD_NOP, CMD_MAC, CMD_SHIFT, CMD_CLEAR, CMD_LOAD, CMD_READ)
  - shift-target constants (IMG_A=0, IMG_B=1)
  - sequencer state enum
  - op-select enum (OP_CLEAR, OP_LOAD, OP_MAC, OP_SHA, OP_SHB, OP_READ)
- Sub-module pe_cmd_handshake:
  - owns ISSUE/WAIT_BUSY/WAIT_DONE, `array_ack` and the timeout counter.
  - interface: cmd_valid/cmd_in/img_in → cmd_done/cmd_timeout, plus abort.
- The top level holds the op sequencer and `step_count`.

Test Plan:
1. Array model: `ready` falls 1 cycle after `array_ack`=0, rises 2 cycles later. `start` with `k_steps`=1 → commands 100, 101, 001, 110 in order; `done` pulses once; `step_count`=1; `error`=0.
2. `k_steps`=3 → exactly 10 commands: CLEAR, LOAD, MAC, SHIFT(0), SHIFT(1), MAC, SHIFT(0), SHIFT(1), MAC, READ. `step_count` ends at 3. Each command is held stable while `array_ack`=0.
3. Array model never drops `ready` on the LOAD command, TIMEOUT=16 → `error`=1 after 16 cycles in WAIT_BUSY; `array_ack`=1; cmd=000; `busy`=0; no `done`. A following start with `k_steps`=1 clears `error` and completes normally.
4. Assert `abort` during the second MAC's WAIT_DONE, same cycle as `ready` rises → next cycle IDLE, `array_ack`=1, no `done`, `step_count`=1.
5. Assert `RST` for one cycle mid-SHIFT → all outputs at reset values the next cycle. `start` with `k_steps`=0 → no command issued, `busy` stays 0.
6. Pulse `start` repeatedly while busy → no restart; the job completes with a single `done`.
